// File: rtl/pid_sample_scheduler_if.sv
// Coefficient staging/commit port between the config interface and the PID sample scheduler.
interface pid_sample_scheduler_if #(
  parameter int REG_BITWIDTH = 32
);
  logic                           cfg_valid;
  logic                           cfg_ready;
  logic [2:0]                     cfg_addr;
  logic signed [REG_BITWIDTH-1:0] cfg_data;
  logic                           cfg_commit;
  logic                           commit_pending;
  logic                           cfg_err;

  modport master (
    output cfg_valid, cfg_addr, cfg_data, cfg_commit,
    input  cfg_ready, commit_pending, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, cfg_commit,
    output cfg_ready, commit_pending, cfg_err
  );
endinterface

// File: rtl/pid_sample_scheduler.sv
// PID core sequencer: periodic sample strobe, overrun counting and atomic
// staging->active commit of the five IIR coefficients while the core is idle.
module pid_sample_scheduler #(
  parameter int REG_BITWIDTH    = 32,
  parameter int PERIOD_BITWIDTH = 16,
  parameter int OVR_BITWIDTH    = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           enable_i,
  input  logic [PERIOD_BITWIDTH-1:0]     period_i,
  input  logic                           busy_i,
  pid_sample_scheduler_if.slave          cfg,
  output logic                           clk_en_PID_o,
  output logic signed [REG_BITWIDTH-1:0] a1_reg_o,
  output logic signed [REG_BITWIDTH-1:0] a0_reg_o,
  output logic signed [REG_BITWIDTH-1:0] b0_reg_o,
  output logic signed [REG_BITWIDTH-1:0] b1_reg_o,
  output logic signed [REG_BITWIDTH-1:0] b2_reg_o,
  output logic [OVR_BITWIDTH-1:0]        overrun_cnt_o
);
  localparam int NUM_COEF = 5;

  typedef enum logic {ST_IDLE, ST_PEND} cstate_t;

  cstate_t                               state_q, state_d;
  logic [NUM_COEF-1:0][REG_BITWIDTH-1:0] stage_q, active_q;
  logic [PERIOD_BITWIDTH-1:0]            cnt_q;
  logic [OVR_BITWIDTH-1:0]               ovr_q;
  logic                                  strobe_q, ready_q, err_q;
  logic                                  tick, wr_en, apply;

  assign tick  = enable_i && (cnt_q == '0);
  assign wr_en = cfg.cfg_valid && ready_q;

  // Apply waits for an idle core and a low strobe so one evaluation sees one coefficient set.
  always_comb begin
    state_d = state_q;
    apply   = 1'b0;
    case (state_q)
      ST_IDLE: if (cfg.cfg_commit) state_d = ST_PEND;
      ST_PEND: if (!busy_i && !strobe_q) begin
        apply   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b1;
      err_q    <= 1'b0;
      cnt_q    <= period_i;
      strobe_q <= 1'b0;
      ovr_q    <= '0;
      stage_q  <= '0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= (state_d == ST_IDLE);
      strobe_q <= tick && !busy_i;
      if (!enable_i || cnt_q == '0) cnt_q <= period_i;
      else                          cnt_q <= cnt_q - PERIOD_BITWIDTH'(1);
      if (tick && busy_i && ovr_q != '1) ovr_q <= ovr_q + OVR_BITWIDTH'(1);
      if (wr_en && cfg.cfg_addr >= 3'(NUM_COEF)) err_q <= 1'b1;
      // Staging reads here see a same-cycle write one edge later, so write+commit includes it.
      for (int i = 0; i < NUM_COEF; i++) begin
        if (wr_en && cfg.cfg_addr == 3'(i)) stage_q[i] <= cfg.cfg_data;
        if (apply)                          active_q[i] <= stage_q[i];
      end
    end
  end

  assign cfg.cfg_ready      = ready_q;
  assign cfg.commit_pending = (state_q == ST_PEND);
  assign cfg.cfg_err        = err_q;
  assign clk_en_PID_o       = strobe_q;
  assign overrun_cnt_o      = ovr_q;
  assign a1_reg_o           = active_q[0];
  assign a0_reg_o           = active_q[1];
  assign b0_reg_o           = active_q[2];
  assign b1_reg_o           = active_q[3];
  assign b2_reg_o           = active_q[4];
endmodule

// File: tb/tb_pid_sample_scheduler.sv
// Directed bench: table-driven staging/commit vectors plus hand sequences for timing corners.
module tb_pid_sample_scheduler;
  logic        clk_i = 1'b0;
  logic        rst_i, enable_i, busy_i;
  logic [15:0] period_i;
  logic        clk_en_PID_o;
  logic signed [31:0] a1_reg_o, a0_reg_o, b0_reg_o, b1_reg_o, b2_reg_o;
  logic [7:0]  overrun_cnt_o;
  int          n_chk = 0;
  int          n_pass = 0;

  pid_sample_scheduler_if #(.REG_BITWIDTH(32)) cfg_if ();

  pid_sample_scheduler dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .period_i(period_i),
    .busy_i(busy_i), .cfg(cfg_if), .clk_en_PID_o(clk_en_PID_o),
    .a1_reg_o(a1_reg_o), .a0_reg_o(a0_reg_o), .b0_reg_o(b0_reg_o),
    .b1_reg_o(b1_reg_o), .b2_reg_o(b2_reg_o), .overrun_cnt_o(overrun_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        valid;
    logic [2:0]  addr;
    logic [31:0] data;
    logic        commit;
    logic        busy;
    logic        e_ready;
    logic        e_pend;
    logic        e_err;
    logic [31:0] e_a1;
    logic [31:0] e_b2;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(bit v, int a, int d, bit c, bit b, bit r, bit p, bit e,
                              int ea1, int eb2);
    vec_t t;
    t = '{v, 3'(a), 32'(d), c, b, r, p, e, 32'(ea1), 32'(eb2)};
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bit v, input int a, input int d, input bit c);
    cfg_if.cfg_valid  = v;
    cfg_if.cfg_addr   = 3'(a);
    cfg_if.cfg_data   = 32'(d);
    cfg_if.cfg_commit = c;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " strobe"}, 32'(clk_en_PID_o), 0);
    check({tag, " pend"}, 32'(cfg_if.commit_pending), 0);
    check({tag, " ready"}, 32'(cfg_if.cfg_ready), 1);
    check({tag, " err"}, 32'(cfg_if.cfg_err), 0);
    check({tag, " ovr"}, 32'(overrun_cnt_o), 0);
    check({tag, " coefs"}, a1_reg_o | a0_reg_o | b0_reg_o | b1_reg_o | b2_reg_o, 0);
  endtask

  initial begin
    //                v  addr data  c  busy rdy pend err  a1   b2
    vecs[0]  = mk(1, 0, 1,   0, 0, 1, 0, 0, 0,   0);
    vecs[1]  = mk(1, 1, 2,   0, 0, 1, 0, 0, 0,   0);
    vecs[2]  = mk(1, 2, 3,   0, 0, 1, 0, 0, 0,   0);
    vecs[3]  = mk(1, 3, 4,   0, 0, 1, 0, 0, 0,   0);
    vecs[4]  = mk(1, 4, 5,   1, 0, 0, 1, 0, 0,   0);
    vecs[5]  = mk(0, 0, 0,   0, 0, 1, 0, 0, 1,   5);
    vecs[6]  = mk(1, 0, 100, 1, 1, 0, 1, 0, 1,   5);
    vecs[7]  = mk(1, 0, 200, 0, 1, 0, 1, 0, 1,   5);
    vecs[8]  = mk(0, 0, 0,   1, 1, 0, 1, 0, 1,   5);
    vecs[9]  = mk(0, 0, 0,   0, 0, 1, 0, 0, 100, 5);
    vecs[10] = mk(1, 6, 77,  0, 0, 1, 0, 1, 100, 5);
    vecs[11] = mk(1, 5, 88,  0, 0, 1, 0, 1, 100, 5);
    vecs[12] = mk(1, 4, 9,   1, 0, 0, 1, 1, 100, 5);
    vecs[13] = mk(0, 0, 0,   0, 0, 1, 0, 1, 100, 9);

    rst_i = 1'b1; enable_i = 1'b0; busy_i = 1'b0; period_i = 16'd9;
    drive(0, 0, 0, 0);
    step(); step();
    check_reset_state("reset");
    rst_i = 1'b0;

    // Staging / commit table, strobes disabled.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].valid, int'(vecs[i].addr), int'(vecs[i].data), vecs[i].commit);
      busy_i = vecs[i].busy;
      step();
      check($sformatf("vec%0d ready", i), 32'(cfg_if.cfg_ready), 32'(vecs[i].e_ready));
      check($sformatf("vec%0d pend", i), 32'(cfg_if.commit_pending), 32'(vecs[i].e_pend));
      check($sformatf("vec%0d err", i), 32'(cfg_if.cfg_err), 32'(vecs[i].e_err));
      check($sformatf("vec%0d a1", i), a1_reg_o, vecs[i].e_a1);
      check($sformatf("vec%0d b2", i), b2_reg_o, vecs[i].e_b2);
    end
    drive(0, 0, 0, 0);
    busy_i = 1'b0;
    check("table a0", a0_reg_o, 2);
    check("table b0", b0_reg_o, 3);
    check("table b1", b1_reg_o, 4);

    // Strobe every 10 cycles, one cycle wide, first one 10 edges after enable.
    enable_i = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      step();
      check($sformatf("period k%0d strobe", k), 32'(clk_en_PID_o), 32'(k % 10 == 0));
    end
    check("period ovr", 32'(overrun_cnt_o), 0);

    // Busy across ticks at edges 50, 60, 70.
    busy_i = 1'b1;
    for (int k = 46; k <= 75; k++) begin
      step();
      if (clk_en_PID_o !== 1'b0) check($sformatf("busy k%0d strobe", k), 32'(clk_en_PID_o), 0);
    end
    check("overrun 3", 32'(overrun_cnt_o), 3);
    period_i = 16'd0;
    for (int k = 0; k < 300; k++) step();
    check("overrun sat", 32'(overrun_cnt_o), 255);
    check("overrun no strobe", 32'(clk_en_PID_o), 0);

    // Continuous strobes (period 0) hold off a commit until the strobe drops.
    busy_i = 1'b0;
    step();
    check("cont strobe", 32'(clk_en_PID_o), 1);
    drive(1, 1, 55, 1);
    step();
    check("cont pend", 32'(cfg_if.commit_pending), 1);
    drive(1, 1, 66, 0);
    for (int k = 0; k < 5; k++) step();
    drive(0, 0, 0, 0);
    check("cont held pend", 32'(cfg_if.commit_pending), 1);
    check("cont held a0", a0_reg_o, 2);
    check("cont held strobe", 32'(clk_en_PID_o), 1);
    enable_i = 1'b0;
    step();
    check("drop strobe", 32'(clk_en_PID_o), 0);
    check("drop pend", 32'(cfg_if.commit_pending), 1);
    step();
    check("apply pend", 32'(cfg_if.commit_pending), 0);
    check("apply a0", a0_reg_o, 55);
    check("apply ready", 32'(cfg_if.cfg_ready), 1);

    // Reset with a pending commit and the counter mid-period.
    period_i = 16'd9;
    step();
    enable_i = 1'b1; busy_i = 1'b1;
    drive(1, 2, 7, 1);
    step();
    drive(0, 0, 0, 0);
    step(); step(); step();
    check("pre-rst pend", 32'(cfg_if.commit_pending), 1);
    rst_i = 1'b1;
    step();
    check_reset_state("midrst");
    rst_i = 1'b0; busy_i = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("post-rst k%0d strobe", k), 32'(clk_en_PID_o), 32'(k == 10));
    end
    check("post-rst b0", b0_reg_o, 0);
    check("post-rst pend", 32'(cfg_if.commit_pending), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
